// File: rtl/shift_ctrl_pkg.sv
// Shared types and constants for the shift-register command sequencer.
// Op codes, FSM states, register mode-select encodings and op classification helpers.
package shift_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_LOAD = 3'd0,
    OP_SHR  = 3'd1,
    OP_SHL  = 3'd2,
    OP_ROTR = 3'd3,
    OP_ROTL = 3'd4
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [1:0] SEL_HOLD  = 2'b00;
  localparam logic [1:0] SEL_RIGHT = 2'b01;
  localparam logic [1:0] SEL_LEFT  = 2'b10;
  localparam logic [1:0] SEL_LOAD  = 2'b11;

  function automatic logic op_legal(input logic [2:0] op);
    return (op <= 3'd4);
  endfunction

  function automatic logic op_is_shift(input logic [2:0] op);
    return (op != 3'd0) && op_legal(op);
  endfunction

endpackage

// File: rtl/shift_register_ctrl.sv
// Command sequencer for a universal shift register: accepts LOAD/shift/rotate
// commands, drives mode selects and fill bits for N cycles, then pulses done.
module shift_register_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             ser_in,
  input  logic             abort,
  input  logic [WIDTH-1:0] sr_q,
  output logic             sr_s1,
  output logic             sr_s0,
  output logic [WIDTH-1:0] sr_in,
  output logic             sr_msb_in,
  output logic             sr_lsb_in,
  output logic             ser_out,
  output logic             ser_out_valid,
  output logic             done,
  output logic             err
);

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             err_q, err_d;
  logic [1:0]       sel_s;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q <= ST_IDLE;
      op_q    <= 3'd0;
      rem_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rem_d   = rem_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d   = cmd_op;
          data_d = cmd_data;
          err_d  = !op_legal(cmd_op);
          if (!op_legal(cmd_op)) begin
            rem_d   = '0;
            state_d = ST_DONE;
          end else if (cmd_op == OP_LOAD) begin
            rem_d   = CNT_W'(1);
            state_d = ST_RUN;
          end else if (cmd_count == '0) begin
            rem_d   = '0;
            state_d = ST_DONE;
          end else begin
            rem_d   = cmd_count;
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        // Saturating decrement keeps the counter from wrapping even on abort.
        if (rem_q != '0) begin
          rem_d = rem_q - CNT_W'(1);
        end else begin
          rem_d = '0;
        end
        if (abort || (rem_q <= CNT_W'(1))) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sel_s         = SEL_HOLD;
    sr_in         = '0;
    sr_msb_in     = 1'b0;
    sr_lsb_in     = 1'b0;
    ser_out       = 1'b0;
    ser_out_valid = 1'b0;
    cmd_ready     = (state_q == ST_IDLE);
    done          = (state_q == ST_DONE);
    err           = (state_q == ST_DONE) && err_q;
    // An abort cycle suppresses the shift so only completed shifts count.
    if ((state_q == ST_RUN) && !abort) begin
      case (op_q)
        OP_LOAD: begin
          sel_s = SEL_LOAD;
          sr_in = data_q;
        end
        OP_SHR: begin
          sel_s         = SEL_RIGHT;
          sr_msb_in     = ser_in;
          ser_out       = sr_q[0];
          ser_out_valid = 1'b1;
        end
        OP_SHL: begin
          sel_s         = SEL_LEFT;
          sr_lsb_in     = ser_in;
          ser_out       = sr_q[WIDTH-1];
          ser_out_valid = 1'b1;
        end
        OP_ROTR: begin
          sel_s         = SEL_RIGHT;
          sr_msb_in     = sr_q[0];
          ser_out       = sr_q[0];
          ser_out_valid = 1'b1;
        end
        OP_ROTL: begin
          sel_s         = SEL_LEFT;
          sr_lsb_in     = sr_q[WIDTH-1];
          ser_out       = sr_q[WIDTH-1];
          ser_out_valid = 1'b1;
        end
        default: sel_s = SEL_HOLD;
      endcase
    end else begin
      sel_s = SEL_HOLD;
    end
  end

  assign sr_s1 = sel_s[1];
  assign sr_s0 = sel_s[0];

endmodule
